// File: rtl/alu_operand_loader_pkg.sv
// Shared definitions for the ALU operand loader and its bench.
// Holds the ALU opcode encodings and the loader FSM state encodings.
package alu_operand_loader_pkg;

  // ALU opcodes carried on op_out
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  // Loader FSM states; the encoding is visible on the state_out debug pins
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GOT_A = 2'b01,
    ST_ISSUE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_operand_loader_if.sv
// Operand word bus between the loader and the ALU.
//  a_out/b_out : operands (WIDTH bits)
//  op_out      : 2-bit opcode
//  opnd_valid  : word complete and stable
//  opnd_ready  : ALU accepts the word
// master = loader side, slave = ALU side.
interface alu_operand_loader_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic [1:0]       op_out;
  logic             opnd_valid;
  logic             opnd_ready;

  modport master (
    output a_out,
    output b_out,
    output op_out,
    output opnd_valid,
    input  opnd_ready
  );

  modport slave (
    input  a_out,
    input  b_out,
    input  op_out,
    input  opnd_valid,
    output opnd_ready
  );
endinterface

// File: rtl/alu_operand_loader_strobe_sync_edge.sv
// Synchronizes the asynchronous load strobe and produces a one-cycle
// rising-edge pulse.
//  clk      : system clock
//  rst_n    : asynchronous active-low reset
//  strb_in  : raw asynchronous strobe
//  edge_out : one-cycle pulse on a synchronized rising edge
// SYNC_STAGES must be at least 2. A level first sampled at edge k is seen
// as a pulse during the cycle that ends at edge k+SYNC_STAGES.
module alu_operand_loader_strobe_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strb_in,
  output logic edge_out
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   edge_q_r;

  // Synchronizer chain plus the delayed copy used for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r   <= '0;
      edge_q_r <= 1'b0;
    end else begin
      sync_r   <= {sync_r[SYNC_STAGES-2:0], strb_in};
      edge_q_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // A held-high strobe yields exactly one pulse
  assign edge_out = sync_r[SYNC_STAGES-1] & ~edge_q_r;

endmodule

// File: rtl/alu_operand_loader.sv
// Upstream stage of the 4-bit ALU. Collects operand A, then operand B with
// the opcode, from a nibble bus on two strobe edges and presents the
// complete word with a valid/ready handshake. Counts completed handshakes
// and flags strobes that arrive while a word is still waiting.
//  clk, rst_n : clock, asynchronous active-low reset
//  ena        : 0 freezes FSM, data, counter and error flag
//  nib_in     : operand nibble, sampled on a strobe edge
//  op_in      : opcode, sampled together with B
//  ld_strb    : asynchronous load strobe, rising edge = load
//  clr        : synchronous clear, wins over everything except rst_n
//  opnd       : operand bus (a_out, b_out, op_out, opnd_valid, opnd_ready)
//  state_out  : FSM state for debug pins
//  txn_cnt    : completed handshakes, wraps
//  ovr_err    : sticky overrun flag
module alu_operand_loader
  import alu_operand_loader_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [WIDTH-1:0]     nib_in,
  input  logic [1:0]           op_in,
  input  logic                 ld_strb,
  input  logic                 clr,
  alu_operand_loader_if.master opnd,
  output logic [1:0]           state_out,
  output logic [CNT_W-1:0]     txn_cnt,
  output logic                 ovr_err
);

  state_e           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [1:0]       op_r;
  logic             valid_r;
  logic [CNT_W-1:0] cnt_r;
  logic             ovr_r;
  logic             edge_s;

  alu_operand_loader_strobe_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .strb_in  (ld_strb),
    .edge_out (edge_s)
  );

  // Loader FSM with its data, counter and error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      op_r    <= 2'b00;
      valid_r <= 1'b0;
      cnt_r   <= '0;
      ovr_r   <= 1'b0;
    end else if (clr) begin
      // Any strobe edge landing in this cycle is dropped
      state_r <= ST_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      op_r    <= 2'b00;
      valid_r <= 1'b0;
      cnt_r   <= '0;
      ovr_r   <= 1'b0;
    end else if (ena) begin
      case (state_r)
        ST_IDLE: begin
          if (edge_s) begin
            a_r     <= nib_in;
            state_r <= ST_GOT_A;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GOT_A: begin
          if (edge_s) begin
            b_r     <= nib_in;
            op_r    <= op_in;
            valid_r <= 1'b1;
            state_r <= ST_ISSUE;
          end else begin
            state_r <= ST_GOT_A;
          end
        end
        ST_ISSUE: begin
          if (opnd.opnd_ready) begin
            cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            valid_r <= 1'b0;
            // A strobe coinciding with acceptance already starts the next word
            if (edge_s) begin
              a_r     <= nib_in;
              state_r <= ST_GOT_A;
            end else begin
              state_r <= ST_IDLE;
            end
          end else if (edge_s) begin
            // Word still pending: keep it intact and record the overrun
            ovr_r <= 1'b1;
          end else begin
            state_r <= ST_ISSUE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          valid_r <= 1'b0;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  assign opnd.a_out      = a_r;
  assign opnd.b_out      = b_r;
  assign opnd.op_out     = op_r;
  assign opnd.opnd_valid = valid_r;
  assign state_out       = state_r;
  assign txn_cnt         = cnt_r;
  assign ovr_err         = ovr_r;

endmodule
